// File: rtl/rx_roce_hdr_parse.sv
// RoCEv2 receive header parser: checks Eth/IPv4/UDP fields at fixed offsets, extracts the BTH
// fields and emits one descriptor per accepted frame; rejected frames are counted in drop_cnt.
module rx_roce_hdr_parse #(
  parameter logic [15:0] ROCE_UDP_PORT = 16'd4791,
  parameter int          BYTE_CNT_W    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           s_axis_tdata,
  input  logic [7:0]            s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [7:0]            host_IPv4_last,
  input  logic [3:0]            QPn_in,
  output logic                  m_hdr_valid,
  input  logic                  m_hdr_ready,
  output logic [3:0]            m_hdr_QPn,
  output logic [7:0]            m_hdr_opcode,
  output logic [23:0]           m_hdr_dest_qp,
  output logic [23:0]           m_hdr_psn,
  output logic [BYTE_CNT_W-1:0] m_hdr_len,
  output logic [15:0]           drop_cnt,
  output logic [2:0]            state_dbg_o
);

  // Stream handshake: a beat transfers on a rising edge where s_axis_tvalid && s_axis_tready;
  // the descriptor transfers on a rising edge where m_hdr_valid && m_hdr_ready.
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [2:0]            beat_q;
  logic [BYTE_CNT_W-1:0] byte_q;
  logic [BYTE_CNT_W-1:0] len_q;
  logic                  tready_q;
  logic [7:0]            host_q;
  logic [3:0]            qpn_q;
  logic [7:0]            opcode_q;
  logic [23:0]           dqp_q;
  logic [23:0]           psn_q;
  logic [15:0]           drop_q;
  logic [3:0]            keep_cnt;
  logic                  accept;
  logic                  hdr_fail;
  logic                  drop_inc;

  assign accept = s_axis_tvalid & tready_q;

  always_comb begin
    keep_cnt = 4'd0;
    for (int i = 0; i < 8; i++) keep_cnt = keep_cnt + {3'b000, s_axis_tkeep[i]};
  end

  // Header checks live on beats 1, 2 and 4; the lookup result is valid on beat 4 because
  // host_IPv4_last was registered from byte 29 on beat 3.
  always_comb begin
    hdr_fail = 1'b0;
    case (beat_q)
      3'd1: hdr_fail = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} != 16'h0800) ||
                       (s_axis_tdata[55:48] != 8'h45);
      3'd2: hdr_fail = (s_axis_tdata[63:56] != 8'd17);
      3'd4: hdr_fail = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} != ROCE_UDP_PORT) ||
                       (QPn_in == 4'd0);
      default: hdr_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    drop_inc = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        // A single-beat frame is already complete, so it is counted and discarded here.
        if (s_axis_tlast) drop_inc = 1'b1;
        else              state_d  = S_HDR;
      end
      S_HDR: if (accept) begin
        if (hdr_fail) begin
          if (s_axis_tlast) begin state_d = S_IDLE; drop_inc = 1'b1; end
          else              state_d = S_DROP;
        end else if (s_axis_tlast) begin
          if (beat_q == 3'd6) state_d = S_OUT;
          else begin state_d = S_IDLE; drop_inc = 1'b1; end
        end else if (beat_q == 3'd6) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (accept && s_axis_tlast) state_d = S_OUT;
      S_DROP: if (accept && s_axis_tlast) begin state_d = S_IDLE; drop_inc = 1'b1; end
      S_OUT: if (m_hdr_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= 3'd0;
      byte_q   <= '0;
      len_q    <= '0;
      tready_q <= 1'b0;
      host_q   <= 8'd0;
      qpn_q    <= 4'd0;
      opcode_q <= 8'd0;
      dqp_q    <= 24'd0;
      psn_q    <= 24'd0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d != S_OUT);
      if (accept) begin
        if (state_q == S_IDLE) begin
          beat_q <= 3'd1;
          byte_q <= BYTE_CNT_W'(keep_cnt);
        end else begin
          beat_q <= (beat_q == 3'd7) ? 3'd7 : beat_q + 3'd1;
          byte_q <= byte_q + BYTE_CNT_W'(keep_cnt);
        end
      end
      if (state_d == S_OUT && state_q != S_OUT) len_q <= byte_q + BYTE_CNT_W'(keep_cnt);
      if (accept && state_q == S_HDR) begin
        case (beat_q)
          3'd3: host_q <= s_axis_tdata[47:40];
          3'd4: qpn_q  <= QPn_in;
          3'd5: begin
            opcode_q     <= s_axis_tdata[23:16];
            dqp_q[23:16] <= s_axis_tdata[63:56];
          end
          3'd6: begin
            dqp_q[15:0] <= {s_axis_tdata[7:0], s_axis_tdata[15:8]};
            psn_q       <= {s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
          end
          default: ;
        endcase
      end
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign s_axis_tready  = tready_q;
  assign host_IPv4_last = host_q;
  assign m_hdr_valid    = (state_q == S_OUT);
  assign m_hdr_QPn      = qpn_q;
  assign m_hdr_opcode   = opcode_q;
  assign m_hdr_dest_qp  = dqp_q;
  assign m_hdr_psn      = psn_q;
  assign m_hdr_len      = len_q;
  assign drop_cnt       = drop_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_rx_roce_hdr_parse.sv
// Directed bench for rx_roce_hdr_parse: valid, rejected, runt, back-pressured, gapped and
// reset-interrupted frames, checked against hand-computed descriptors.
module tb_rx_roce_hdr_parse;

  localparam int BW = 14;
  localparam int DW = 4 + 8 + 24 + 24 + BW;

  logic          clk, rst;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]    host_IPv4_last;
  logic [3:0]    QPn_in;
  logic          m_hdr_valid, m_hdr_ready;
  logic [3:0]    m_hdr_QPn;
  logic [7:0]    m_hdr_opcode;
  logic [23:0]   m_hdr_dest_qp, m_hdr_psn;
  logic [BW-1:0] m_hdr_len;
  logic [15:0]   drop_cnt;
  logic [2:0]    state_dbg_o;

  rx_roce_hdr_parse #(.ROCE_UDP_PORT(16'd4791), .BYTE_CNT_W(BW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .host_IPv4_last(host_IPv4_last), .QPn_in(QPn_in),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr_QPn(m_hdr_QPn),
    .m_hdr_opcode(m_hdr_opcode), .m_hdr_dest_qp(m_hdr_dest_qp), .m_hdr_psn(m_hdr_psn),
    .m_hdr_len(m_hdr_len), .drop_cnt(drop_cnt), .state_dbg_o(state_dbg_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // QPn lookup: only host .10 is known
  logic [3:0] lut_val;
  assign QPn_in = (host_IPv4_last == 8'd10) ? lut_val : 4'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int wait_cycles = 0;
  logic [7:0]    fb [64];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;
  logic [15:0]   exp_drop;

  // Expected descriptor for the reference frame: QPn 2, opcode 0x0A, QP 0x11, PSN 0x123, 60 bytes
  localparam logic [DW-1:0] REF_DESC = {4'd2, 8'h0A, 24'h000011, 24'h000123, 14'd60};

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [15:0] port);
    for (int i = 0; i < 64; i++) fb[i] = 8'(i + 8'h60);
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'd17;
    fb[29] = 8'd10; fb[36] = port[15:8]; fb[37] = port[7:0];
    fb[42] = 8'h0A; fb[47] = 8'h00; fb[48] = 8'h00; fb[49] = 8'h11;
    fb[51] = 8'h00; fb[52] = 8'h01; fb[53] = 8'h23;
  endtask

  // driver: present a beat at a falling edge, hold until tready is seen, then release
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    n = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 20) begin @(negedge clk); n++; end
    wait_cycles += n;
    if (!s_axis_tready) begin
      n_cmp++; n_bad++;
      $error("FAIL beat_timeout: observed tready 0 expected 1 within 20 cycles");
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] port, input int nbeats, input bit gaps,
                            input bit open_end);
    logic [63:0] d;
    build_frame(port);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && b >= 1 && b <= 6) repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < 8; i++) d[8*i +: 8] = fb[8*b + i];
      send_beat(d, (b == 7) ? 8'h0F : 8'hFF, (b == nbeats - 1) && !open_end);
    end
  endtask

  task automatic check_desc(input string tag, input bit pop);
    logic [DW-1:0] e;
    e = pop ? exp_q.pop_front() : exp_q[0];
    chk({tag, "_valid"},  m_hdr_valid,   1);
    chk({tag, "_qpn"},    m_hdr_QPn,     e[DW-1 -: 4]);
    chk({tag, "_opcode"}, m_hdr_opcode,  e[DW-5 -: 8]);
    chk({tag, "_destqp"}, m_hdr_dest_qp, e[DW-13 -: 24]);
    chk({tag, "_psn"},    m_hdr_psn,     e[DW-37 -: 24]);
    chk({tag, "_len"},    m_hdr_len,     e[BW-1:0]);
    chk({tag, "_tready"}, s_axis_tready, 0);
  endtask

  task automatic handshake(input string tag);
    m_hdr_ready = 1'b1;
    @(negedge clk);
    m_hdr_ready = 1'b0;
    chk({tag, "_valid_drop"}, m_hdr_valid, 0);
    chk({tag, "_tready_back"}, s_axis_tready, 1);
  endtask

  initial begin
    rst = 1'b1; lut_val = 4'd2; m_hdr_ready = 1'b0; exp_drop = 16'd0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_valid", m_hdr_valid, 0);
    chk("rst_fields", {m_hdr_QPn, m_hdr_opcode, m_hdr_dest_qp, m_hdr_psn, m_hdr_len}, 0);
    chk("rst_host", host_IPv4_last, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_state", state_dbg_o, 0);
    rst = 1'b0;
    #1 chk("tready_before_edge", s_axis_tready, 0);
    @(negedge clk);
    chk("tready_after_edge", s_axis_tready, 1);

    // valid frame
    exp_q.push_back(REF_DESC);
    send_frame(16'd4791, 8, 1'b0, 1'b0);
    check_desc("valid1", 1'b1);
    chk("valid1_state", state_dbg_o, 3'd4);
    chk("valid1_host", host_IPv4_last, 8'd10);
    handshake("valid1");

    // wrong UDP port: dropped, tready never falls
    wait_cycles = 0;
    send_frame(16'd4790, 8, 1'b0, 1'b0);
    exp_drop = exp_drop + 16'd1;
    chk("udp_no_desc", m_hdr_valid, 0);
    chk("udp_drop", drop_cnt, exp_drop);
    chk("udp_tready_waits", wait_cycles, 0);
    chk("udp_tready", s_axis_tready, 1);

    // unknown host, then a good frame
    lut_val = 4'd0;
    send_frame(16'd4791, 8, 1'b0, 1'b0);
    exp_drop = exp_drop + 16'd1;
    chk("unk_no_desc", m_hdr_valid, 0);
    chk("unk_drop", drop_cnt, exp_drop);
    lut_val = 4'd2;
    exp_q.push_back(REF_DESC);
    send_frame(16'd4791, 8, 1'b0, 1'b0);
    check_desc("after_unk", 1'b1);
    handshake("after_unk");

    // runt: tlast on beat 3
    send_frame(16'd4791, 4, 1'b0, 1'b0);
    exp_drop = exp_drop + 16'd1;
    chk("runt_no_desc", m_hdr_valid, 0);
    chk("runt_drop", drop_cnt, exp_drop);
    chk("runt_state", state_dbg_o, 3'd0);

    // back-pressure on the descriptor for 5 cycles
    exp_q.push_back(REF_DESC);
    send_frame(16'd4791, 8, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check_desc("hold", 1'b0);
      @(negedge clk);
    end
    check_desc("hold_end", 1'b1);
    m_hdr_ready = 1'b1;
    @(negedge clk);
    m_hdr_ready = 1'b0;
    wait_cycles = 0;
    exp_q.push_back(REF_DESC);
    send_frame(16'd4791, 8, 1'b0, 1'b0);
    chk("b2b_first_beat_waits", wait_cycles, 0);
    check_desc("b2b", 1'b1);
    handshake("b2b");

    // tvalid gaps inside the header give the same descriptor
    exp_q.push_back(REF_DESC);
    send_frame(16'd4791, 8, 1'b1, 1'b0);
    check_desc("gaps", 1'b1);
    handshake("gaps");

    // reset in the middle of the payload discards frame without counting a drop
    send_frame(16'd4791, 7, 1'b1, 1'b1);
    chk("mid_state_payload", state_dbg_o, 3'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_valid", m_hdr_valid, 0);
    chk("mid_rst_fields", {m_hdr_QPn, m_hdr_opcode, m_hdr_dest_qp, m_hdr_psn, m_hdr_len}, 0);
    chk("mid_rst_host", host_IPv4_last, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tready_rise", s_axis_tready, 1);
    exp_q.push_back(REF_DESC);
    send_frame(16'd4791, 8, 1'b0, 1'b0);
    check_desc("post_rst", 1'b1);
    chk("post_rst_drop", drop_cnt, 0);
    handshake("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
